// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - event class encodings and scan-code constants
//   - packed key-event record (16 bits) pushed through the event FIFO
//   - decode FSM state type
//   - scan-code classification and "ignored code" helpers
`timescale 1ns/1ps
package ps2_pkg;

  localparam logic [1:0] CLS_LETTER = 2'd0;
  localparam logic [1:0] CLS_NUMBER = 2'd1;
  localparam logic [1:0] CLS_ENTER  = 2'd2;
  localparam logic [1:0] CLS_OTHER  = 2'd3;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [3:0] VAL_NONE = 4'hF;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [1:0] cls;
    logic [3:0] value;
  } ps2_event_t;

  localparam ps2_event_t EVENT_RESET = '{code: 8'h00, ext: 1'b0, rel: 1'b0,
                                         cls: CLS_OTHER, value: VAL_NONE};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Keyboard responses / pause prefix: swallowed without touching decode state.
  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // Returns {class, value} for an unextended scan code.
  function automatic logic [5:0] classify(input logic [7:0] code);
    case (code)
      8'h1C: return {CLS_LETTER, 4'd0};
      8'h32: return {CLS_LETTER, 4'd1};
      8'h21: return {CLS_LETTER, 4'd2};
      8'h23: return {CLS_LETTER, 4'd3};
      8'h24: return {CLS_LETTER, 4'd4};
      8'h2B: return {CLS_LETTER, 4'd5};
      8'h34: return {CLS_LETTER, 4'd6};
      8'h33: return {CLS_LETTER, 4'd7};
      8'h43: return {CLS_LETTER, 4'd8};
      8'h3B: return {CLS_LETTER, 4'd9};
      8'h45: return {CLS_NUMBER, 4'd0};
      8'h16: return {CLS_NUMBER, 4'd1};
      8'h1E: return {CLS_NUMBER, 4'd2};
      8'h26: return {CLS_NUMBER, 4'd3};
      8'h25: return {CLS_NUMBER, 4'd4};
      8'h2E: return {CLS_NUMBER, 4'd5};
      8'h36: return {CLS_NUMBER, 4'd6};
      8'h3D: return {CLS_NUMBER, 4'd7};
      8'h3E: return {CLS_NUMBER, 4'd8};
      8'h46: return {CLS_NUMBER, 4'd9};
      SC_ENTER: return {CLS_ENTER, VAL_NONE};
      default:  return {CLS_OTHER, VAL_NONE};
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO for decoded key events.
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write request and data (dropped when full unless popping)
//   pop, dout   : read request and head-of-queue data (combinational)
//   full, empty : occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
`timescale 1ns/1ps
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: PS/2 keyboard receiver, scan-code decoder and event FIFO.
//   clock50        : system clock
//   reset          : asynchronous active-high reset
//   keyboardClock  : raw PS/2 clock
//   keyboardData   : raw PS/2 data
//   eventValid     : FIFO head holds an event
//   eventReady     : consumer pops the head when eventValid && eventReady
//   eventCode      : scan code with prefixes stripped
//   eventExtended  : code was E0-prefixed
//   eventRelease   : 1 = break, 0 = make
//   eventClass     : 0 letter, 1 number, 2 enter, 3 other
//   eventValue     : letter/digit value, 4'hF otherwise
//   frameError     : one-cycle pulse on a malformed frame
//   overflow       : sticky, an event was dropped on a full FIFO
// Build option: define PS2_PARITY_CHECK_EN to treat parity failures as
// frame errors; otherwise only start/stop bits are checked.
`timescale 1ns/1ps
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic       eventValid,
  input  logic       eventReady,
  output logic [7:0] eventCode,
  output logic       eventExtended,
  output logic       eventRelease,
  output logic [1:0] eventClass,
  output logic [3:0] eventValue,
  output logic       frameError,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

  // ---------------- synchroniser / edge detect ----------------
  logic [SYNC_STAGES-1:0] kclk_sync;
  logic [SYNC_STAGES-1:0] kdat_sync;
  logic                   kclk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  assign clk_s = kclk_sync[SYNC_STAGES-1];
  assign dat_s = kdat_sync[SYNC_STAGES-1];
  assign fall  = kclk_prev && !clk_s;

  // Lines idle high, so reset to '1 to avoid a spurious falling edge.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      kclk_sync <= '1;
      kdat_sync <= '1;
      kclk_prev <= 1'b1;
    end else begin
      kclk_sync <= {kclk_sync[SYNC_STAGES-2:0], keyboardClock};
      kdat_sync <= {kdat_sync[SYNC_STAGES-2:0], keyboardData};
      kclk_prev <= clk_s;
    end
  end

  // ---------------- frame receiver ----------------
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;      // [0] start bit, [8:1] data byte once full
  logic [TW-1:0] idle_cnt;
  logic          frame_ok;
  logic          frame_vld;
  logic          frame_err;
  logic [7:0]    frame_code;
`ifdef PS2_PARITY_CHECK_EN
  logic          parity_q;
`endif

  // Evaluated on the stop-bit edge, where dat_s is the stop bit itself.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = !shreg[0] && dat_s && (^{shreg[8:1], parity_q});
`else
    frame_ok = !shreg[0] && dat_s;
`endif
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      frame_vld  <= 1'b0;
      frame_err  <= 1'b0;
      frame_code <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          frame_code <= shreg[8:1];
          if (frame_ok) frame_vld <= 1'b1;
          else          frame_err <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt <= 4'd8) shreg <= {dat_s, shreg[8:1]};
`ifdef PS2_PARITY_CHECK_EN
          if (bit_cnt == 4'd9) parity_q <= dat_s;
`endif
        end
      end else if (idle_cnt == IDLE_MAX) begin
        // Saturated: keep discarding any partial frame until the next edge.
        bit_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  assign frameError = frame_err;

  // ---------------- decode FSM ----------------
  dec_state_t state_q;
  dec_state_t state_d;
  logic       push;
  logic       push_ext;
  logic       push_rel;
  logic [5:0] cls_val;
  ps2_event_t push_ev;

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_ext = 1'b0;
    push_rel = 1'b0;
    if (frame_vld && !is_ignored(frame_code)) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_code == SC_BREAK)    state_d = ST_BRK;
          else if (frame_code == SC_EXT) state_d = ST_EXT;
          else                           push    = 1'b1;
        end
        ST_EXT: begin
          if (frame_code == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            push     = 1'b1;
            push_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          push     = 1'b1;
          push_rel = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push     = 1'b1;
          push_ext = 1'b1;
          push_rel = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cls_val       = classify(frame_code);
    push_ev       = EVENT_RESET;
    push_ev.code  = frame_code;
    push_ev.ext   = push_ext;
    push_ev.rel   = push_rel;
    push_ev.cls   = push_ext ? CLS_OTHER : cls_val[5:4];
    push_ev.value = push_ext ? VAL_NONE  : cls_val[3:0];
  end

  // ---------------- event FIFO ----------------
  ps2_event_t fifo_dout;
  ps2_event_t head_hold;
  ps2_event_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign pop = eventReady && !fifo_empty;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk   (clock50),
    .rst   (reset),
    .push  (push),
    .din   (push_ev),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The read slot after a pop holds stale data, so the last real head is
  // kept in a register and shown while the FIFO is empty.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      head_hold <= EVENT_RESET;
      overflow  <= 1'b0;
    end else begin
      if (!fifo_empty) head_hold <= fifo_dout;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign head          = fifo_empty ? head_hold : fifo_dout;
  assign eventValid    = !fifo_empty;
  assign eventCode     = head.code;
  assign eventExtended = head.ext;
  assign eventRelease  = head.rel;
  assign eventClass    = head.cls;
  assign eventValue    = head.value;

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Parametrised PS/2 keyboard receiver and scan-code decoder. It oversamples the PS/2 clock and data lines in the system clock domain and checks each 11-bit frame. It tracks the F0 (break) and E0 (extended) prefixes and pushes one decoded key event per make or break into an internal FIFO, which the game logic reads through a valid/ready handshake. It replaces the older free-running shift-register decoder on the board's PS/2 port.

## Interface
- SYNC_STAGES, 2, flip-flop stages on keyboardClock/keyboardData (min 2)
- FIFO_DEPTH, 8, event FIFO entries; power of 2, min 2
- TIMEOUT_CYCLES, 100000, clock50 cycles with no PS/2 falling edge before a partial frame is discarded (2 ms at 50 MHz)

Ports:
- clock50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- keyboardClock  in  1  raw PS/2 clock
- keyboardData  in  1  raw PS/2 data
- eventValid  out  1  FIFO head holds an event
- eventReady  in  1  consumer accepts the head on eventValid && eventReady
- eventCode  out  8  raw scan code (prefixes stripped)
- eventExtended  out  1  code was E0-prefixed
- eventRelease  out  1  1 = break (F0 seen), 0 = make
- eventClass  out  2  0 LETTER (A–J), 1 NUMBER (0–9), 2 ENTER, 3 OTHER
- eventValue  out  4  letter A–J→0–9; digit key→its digit (0x45→0); ENTER/OTHER→4'hF
- frameError  out  1  one-cycle pulse on a bad frame
- overflow  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- Synchroniser: both lines pass through SYNC_STAGES flops. A falling edge is synced clock 1→0 between consecutive cycles. Data is sampled on that edge cycle.
- Frame receiver: counts edges 0..10 and shifts LSB-first. Edge 0 is the start bit, edges 1–8 are data, edge 9 is odd parity, edge 10 is the stop bit.
- Frame check: start=0, stop=1, and odd parity over data+parity. Failure pulses frameError and discards the frame. The decode state is unchanged.
- Timeout: the counter restarts on every edge. Reaching TIMEOUT_CYCLES with the bit count ≠0 clears the bit count without raising frameError.
- Decode FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0).
  - IDLE: F0→BRK, E0→EXT, other→push make, stay IDLE.
  - EXT: F0→EXT_BRK, other→push make with extended=1, →IDLE.
  - BRK: any code→push break, →IDLE.
  - EXT_BRK: any code→push break with extended=1, →IDLE.
  - Codes E1 and FA/AA/EE/FE/00/FF: no push, state unchanged.
- Classification uses only unextended codes; every extended code is OTHER. Letter map: 1C,32,21,23,24,2B,34,33,43,3B→0..9. Number map: 16,1E,26,25,2E,36,3D,3E,46→1..9 and 45→0. Enter is 5A.
- FIFO:
  - Push when full: the event is dropped and overflow is set; it is cleared only by reset.
  - Pop and push in the same cycle while full: the pop frees a slot, the push is accepted and there is no overflow.
  - Empty: eventValid=0 and the event* outputs hold the last head value.

## Timing
- Reset: eventValid, frameError and overflow = 0. eventCode=0, eventExtended=0, eventRelease=0, eventClass=3, eventValue=4'hF. FSM→IDLE, bit count 0, FIFO empty.
- Reset mid-frame drops the partial frame and any pending prefix.
- Latency: the stop-bit edge is detected in cycle N. The check and decode are registered in N+1. With an empty FIFO, eventValid=1 in cycle N+2.
- The head is stable while eventValid && !eventReady. After a pop, the next entry appears in the following cycle.
- frameError is high for exactly cycle N+1.

## Configuration
- PS2_PARITY_CHECK_EN defined: a parity failure is a frame error, as described above.
- Undefined: the parity bit is ignored, and only start/stop failures raise frameError.

## Structure
- Package ps2_pkg holds:
  - the class encoding localparams (CLS_LETTER…CLS_OTHER)
  - scan-code constants (SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A)
  - the letter/number lookup function
  - the packed event struct (code, extended, release, class, value = 16 bits)
- Sub-module ps2_event_fifo: synchronous FIFO parametrised by FIFO_DEPTH and width 16, with full/empty, push/pop and same-cycle push+pop.

## Test plan
- Frame 1C with parity 0, eventReady=1 → one event: code 1C, class 0, value 0, release 0.
- Sequence F0,16 → a single event: code 16, class 1, value 1, release 1. The F0 frame alone produces no event.
- Sequence E0,5A then E0,F0,5A → make then break: extended=1, class 3, value F.
- Frame 24 with the parity bit flipped → frameError pulses once and there is no event. With PS2_PARITY_CHECK_EN undefined, the same frame yields code 24, class 0, value 4.
- eventReady=0 and FIFO_DEPTH+1 makes of 45 → FIFO_DEPTH events, overflow=1. Draining returns FIFO_DEPTH events, all value 0.
- Six bits of a frame, then idle past TIMEOUT_CYCLES, then a full frame 3B → only code 3B, value 9, and no frameError.
